// File: rtl/xor_cipher_pkg.sv
// Shared types for the XOR cipher sequencer: FSM states, host command
// opcodes, error codes and default geometry.
package xor_cipher_pkg;

  localparam int KEY_BITS_DEF       = 32;
  localparam int MSG_BITS_DEF       = 512;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_KEY = 3'd1,
    ST_LOAD_MSG = 3'd2,
    ST_WAIT_KEY = 3'd3,
    ST_ENCRYPT  = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_ERROR    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_LOAD_KEY = 2'b01,
    OP_LOAD_MSG = 2'b10,
    OP_START    = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'b00,
    ERR_START_EARLY = 2'b01,
    ERR_TIMEOUT     = 2'b10,
    ERR_BUSY_CMD    = 2'b11
  } err_code_e;

  // States in which the sequencer waits on the downstream datapath.
  function automatic logic is_wait_state(state_e s);
    return (s == ST_WAIT_KEY) || (s == ST_ENCRYPT) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/xor_cipher_seq_ctrl_if.sv
// Host-side port of the sequencer: command valid/ready handshake plus
// the qualified serial bit stream.
interface xor_cipher_seq_ctrl_if import xor_cipher_pkg::*; ();

  logic    cmd_valid;
  cmd_op_e cmd_op;
  logic    cmd_ready;
  logic    bit_in;
  logic    bit_valid;

  // Host side drives commands and bits.
  modport master (
    output cmd_valid, cmd_op, bit_in, bit_valid,
    input  cmd_ready
  );

  // Sequencer side accepts them.
  modport slave (
    input  cmd_valid, cmd_op, bit_in, bit_valid,
    output cmd_ready
  );

endinterface

// File: rtl/xor_ctrl_watchdog.sv
// Wait-state watchdog: counts enabled cycles while run is high, restarts
// on clr, and flags expired once TIMEOUT_CYCLES cycles have elapsed since
// the last clear. Only instantiated when XOR_CTRL_WATCHDOG_EN is defined.
module xor_ctrl_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int            W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // The counter value equals cycles spent in the current wait state, so
  // reaching LAST means this is the TIMEOUT_CYCLES-th cycle there.
  assign expired = run && (cnt_q == LAST);

  // Next count: restart on clear, otherwise advance and saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ena) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/xor_cipher_seq_ctrl.sv
// Sequencer for the XOR cipher datapath. Accepts host commands, forwards
// serial key/message bits with a registered load strobe, starts encryption
// once both are complete and waits for the serializer to drain.
// Optional feature: define XOR_CTRL_WATCHDOG_EN to bound each wait state
// by TIMEOUT_CYCLES; without it the wait states block indefinitely.
module xor_cipher_seq_ctrl import xor_cipher_pkg::*; #(
  parameter int KEY_BITS       = KEY_BITS_DEF,
  parameter int MSG_BITS       = MSG_BITS_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  xor_cipher_seq_ctrl_if.slave        host,
  output logic                        serial_data,
  output logic                        load_key,
  output logic                        load_msg,
  input  logic                        key_ready,
  input  logic                        encrypt_done,
  input  logic                        serial_end,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [1:0]                  err_code
);

  localparam int                CNT_W    = $clog2(MSG_BITS) + 1;
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BITS - 1);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BITS - 1);

  // The bit counter is sized from the message length, so the key must fit.
  if (KEY_BITS < 1 || KEY_BITS > MSG_BITS || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("xor_cipher_seq_ctrl: invalid KEY_BITS/MSG_BITS/TIMEOUT_CYCLES");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              key_loaded_q, key_loaded_d;
  logic              msg_loaded_q, msg_loaded_d;
  logic              serial_data_q, serial_data_d;
  logic              load_key_q, load_key_d;
  logic              load_msg_q, load_msg_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  err_code_e         err_code_q, err_code_d;
  logic              held_cmd_q, held_cmd_d;

  logic              cmd_ready_int;
  logic              cmd_acc;
  logic              wd_expired;

  // Commands are taken only in IDLE and ERROR, and never while frozen.
  assign cmd_ready_int  = ena && ((state_q == ST_IDLE) || (state_q == ST_ERROR));
  assign cmd_acc        = host.cmd_valid && cmd_ready_int;
  assign host.cmd_ready = cmd_ready_int;

`ifdef XOR_CTRL_WATCHDOG_EN
  logic wd_run;
  assign wd_run = is_wait_state(state_q);

  // Any state change restarts the count, so each wait state gets a full budget.
  xor_ctrl_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .clr     (state_d != state_q),
    .run     (wd_run),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // Next-state, counter, flag and output-register logic for one enabled cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    key_loaded_d  = key_loaded_q;
    msg_loaded_d  = msg_loaded_q;
    serial_data_d = serial_data_q;
    load_key_d    = 1'b0;
    load_msg_d    = 1'b0;
    done_d        = 1'b0;
    err_d         = err_q;
    err_code_d    = err_code_q;
    held_cmd_d    = 1'b0;

    // A command refused for two consecutive cycles is a host protocol
    // error; it is flagged but the running sequence carries on.
    if (!cmd_ready_int) begin
      held_cmd_d = host.cmd_valid;
      if (host.cmd_valid && held_cmd_q) begin
        err_d      = 1'b1;
        err_code_d = ERR_BUSY_CMD;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          unique case (host.cmd_op)
            OP_LOAD_KEY: begin
              state_d      = ST_LOAD_KEY;
              cnt_d        = '0;
              key_loaded_d = 1'b0;
            end
            OP_LOAD_MSG: begin
              state_d      = ST_LOAD_MSG;
              cnt_d        = '0;
              msg_loaded_d = 1'b0;
            end
            OP_START: begin
              if (key_loaded_q && msg_loaded_q) begin
                state_d = ST_WAIT_KEY;
              end else begin
                state_d    = ST_ERROR;
                err_d      = 1'b1;
                err_code_d = ERR_START_EARLY;
              end
            end
            default: ;
          endcase
        end
      end

      ST_LOAD_KEY: begin
        if (host.bit_valid) begin
          serial_data_d = host.bit_in;
          load_key_d    = 1'b1;
          if (cnt_q == KEY_LAST) begin
            cnt_d        = '0;
            key_loaded_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_LOAD_MSG: begin
        if (host.bit_valid) begin
          serial_data_d = host.bit_in;
          load_msg_d    = 1'b1;
          if (cnt_q == MSG_LAST) begin
            cnt_d        = '0;
            msg_loaded_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_WAIT_KEY: begin
        if (key_ready) begin
          state_d = ST_ENCRYPT;
        end else if (wd_expired) begin
          state_d    = ST_ERROR;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end

      ST_ENCRYPT: begin
        if (encrypt_done && serial_end) begin
          state_d      = ST_IDLE;
          done_d       = 1'b1;
          msg_loaded_d = 1'b0;
        end else if (encrypt_done) begin
          state_d = ST_DRAIN;
        end else if (wd_expired) begin
          state_d    = ST_ERROR;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end

      ST_DRAIN: begin
        if (serial_end) begin
          state_d      = ST_IDLE;
          done_d       = 1'b1;
          msg_loaded_d = 1'b0;
        end else if (wd_expired) begin
          state_d    = ST_ERROR;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end

      ST_ERROR: begin
        // Only NOP recovers; the loaded flags are dropped because the
        // host cannot know which partial load caused the error.
        if (cmd_acc && (host.cmd_op == OP_NOP)) begin
          state_d      = ST_IDLE;
          err_d        = 1'b0;
          err_code_d   = ERR_NONE;
          key_loaded_d = 1'b0;
          msg_loaded_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; everything holds while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      key_loaded_q  <= 1'b0;
      msg_loaded_q  <= 1'b0;
      serial_data_q <= 1'b0;
      load_key_q    <= 1'b0;
      load_msg_q    <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
      held_cmd_q    <= 1'b0;
    end else if (ena) begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_loaded_q  <= key_loaded_d;
      msg_loaded_q  <= msg_loaded_d;
      serial_data_q <= serial_data_d;
      load_key_q    <= load_key_d;
      load_msg_q    <= load_msg_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      held_cmd_q    <= held_cmd_d;
    end
  end

  // Strobes are masked while frozen so the datapath never loads in that
  // window; a pending strobe reappears once ena returns.
  assign serial_data = serial_data_q;
  assign load_key    = load_key_q & ena;
  assign load_msg    = load_msg_q & ena;
  assign done        = done_q & ena;
  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_xor_cipher_seq_ctrl.sv
// Self-checking bench for xor_cipher_seq_ctrl (define XOR_CTRL_WATCHDOG_EN
// to include the timeout sequence).
module tb_xor_cipher_seq_ctrl;
  import xor_cipher_pkg::*;

  localparam int KEY_BITS       = 32;
  localparam int MSG_BITS       = 512;
  localparam int TIMEOUT_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       key_ready = 1'b0;
  logic       encrypt_done = 1'b0;
  logic       serial_end = 1'b0;
  logic       serial_data, load_key, load_msg, busy, done, err;
  logic [1:0] err_code;

  int n_pass  = 0;
  int n_total = 0;

  xor_cipher_seq_ctrl_if host ();

  xor_cipher_seq_ctrl #(
    .KEY_BITS       (KEY_BITS),
    .MSG_BITS       (MSG_BITS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .host         (host),
    .serial_data  (serial_data),
    .load_key     (load_key),
    .load_msg     (load_msg),
    .key_ready    (key_ready),
    .encrypt_done (encrypt_done),
    .serial_end   (serial_end),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ena;
    logic       cv;
    cmd_op_e    op;
    logic [4:0] exp;   // {busy, cmd_ready, err, err_code}
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int status();
    return int'({busy, host.cmd_ready, err, err_code});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    ena = 1'b1; host.cmd_valid = 1'b0; host.bit_valid = 1'b0;
    key_ready = 1'b0; encrypt_done = 1'b0; serial_end = 1'b0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic send_cmd(input cmd_op_e op);
    host.cmd_valid = 1'b1; host.cmd_op = op;
    tick();
    host.cmd_valid = 1'b0;
  endtask

  // Loads one key or message with random bits, gaps and ena drops. The
  // model tracks bits still owed and the strobe owed for this cycle.
  task automatic load_run(input logic is_key, input int pause_at, input int hold_at);
    int   n = is_key ? KEY_BITS : MSG_BITS;
    int   rem = n;
    int   strobes = 0;
    int   pause = 0;
    int   hold = 0;
    logic paused = 1'b0, held = 1'b0;
    logic pend = 1'b0, pend_bit = 1'b0, acc;
    host.cmd_valid = 1'b1; host.bit_valid = 1'b0; ena = 1'b1;
    host.cmd_op = is_key ? OP_LOAD_KEY : OP_LOAD_MSG;
    #1 check("load_cmd_ready", int'(host.cmd_ready), 1);
    tick();
    host.cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 8 * n + 50 && (rem > 0 || pend); cyc++) begin
      if (!paused && pause_at >= 0 && rem <= pause_at && !pend && hold == 0) begin
        pause = 5; paused = 1'b1;
      end
      if (!held && hold_at >= 0 && rem <= hold_at && pause == 0) begin
        hold = 3; held = 1'b1;
      end
      if (pause > 0) begin
        ena = 1'b0; host.bit_valid = pause[0]; pause--;
      end else begin
        ena = (pend || hold > 0) ? 1'b1 : ($urandom_range(0, 5) != 0);
        host.bit_valid = ($urandom_range(0, 3) != 0);
      end
      host.bit_in    = 1'($urandom_range(0, 1));
      host.cmd_valid = (hold > 0);
      host.cmd_op    = OP_START;
      if (hold > 0) hold--;
      #1;
      check("strobe", int'({load_key, load_msg}),
            pend ? (is_key ? 2 : 1) : 0);
      if (pend) check("serial_data", int'(serial_data), int'(pend_bit));
      check("load_busy", int'(busy), (rem > 0) ? 1 : 0);
      if (host.cmd_valid) check("busy_cmd_ready", int'(host.cmd_ready), 0);
      if ((is_key ? load_key : load_msg) === 1'b1) strobes++;
      acc = ena && host.bit_valid && (rem > 0);
      if (acc) begin pend_bit = host.bit_in; rem--; end
      pend = acc;
      tick();
    end
    host.cmd_valid = 1'b0; host.bit_valid = 1'b0; ena = 1'b1;
    check(is_key ? "key_bits_left" : "msg_bits_left", rem, 0);
    check(is_key ? "key_strobe_count" : "msg_strobe_count", strobes, n);
    if (hold_at >= 0) check("busy_cmd_err", int'({err, err_code}), 7);
    else              check("load_no_err", int'(err), 0);
  endtask

  task automatic run_crypto(input logic same_cycle);
    host.cmd_valid = 1'b1; host.cmd_op = OP_START;
    #1 check("start_ready", int'(host.cmd_ready), 1);
    tick();
    host.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("wait_key_busy", int'({busy, done, err}), 4);
      tick();
    end
    key_ready = 1'b1; tick(); key_ready = 1'b0;
    #1 check("encrypt_busy", int'({busy, done}), 2);
    tick();
    if (same_cycle) begin
      encrypt_done = 1'b1; serial_end = 1'b1; tick();
      encrypt_done = 1'b0; serial_end = 1'b0;
    end else begin
      encrypt_done = 1'b1; tick(); encrypt_done = 1'b0;
      for (int i = 0; i < 2; i++) begin
        #1 check("drain_busy", int'({busy, done}), 2);
        tick();
      end
      serial_end = 1'b1; tick(); serial_end = 1'b0;
    end
    #1 check("done_pulse", int'({busy, done, err}), 2);
    tick();
    #1 check("done_single", int'({busy, done}), 0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[16];
    int   n;
    host.cmd_valid = 1'b0; host.cmd_op = OP_NOP;
    host.bit_in = 1'b0; host.bit_valid = 1'b0;

    vecs[0]  = '{1'b1, 1'b1, OP_NOP,      5'b01000};
    vecs[1]  = '{1'b1, 1'b1, OP_START,    5'b11101};
    vecs[2]  = '{1'b1, 1'b1, OP_LOAD_KEY, 5'b11101};
    vecs[3]  = '{1'b1, 1'b1, OP_START,    5'b11101};
    vecs[4]  = '{1'b1, 1'b0, OP_NOP,      5'b11101};
    vecs[5]  = '{1'b1, 1'b1, OP_NOP,      5'b01000};
    vecs[6]  = '{1'b0, 1'b1, OP_START,    5'b00000};
    vecs[7]  = '{1'b1, 1'b1, OP_START,    5'b11101};
    vecs[8]  = '{1'b0, 1'b1, OP_NOP,      5'b10101};
    vecs[9]  = '{1'b1, 1'b1, OP_NOP,      5'b01000};
    vecs[10] = '{1'b1, 1'b1, OP_LOAD_MSG, 5'b10000};
    vecs[11] = '{1'b1, 1'b0, OP_NOP,      5'b10000};
    vecs[12] = '{1'b1, 1'b1, OP_START,    5'b10000};
    vecs[13] = '{1'b1, 1'b0, OP_NOP,      5'b10000};
    vecs[14] = '{1'b1, 1'b1, OP_NOP,      5'b10000};
    vecs[15] = '{1'b1, 1'b1, OP_NOP,      5'b10111};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("reset_state",
             int'({busy, host.cmd_ready, err, err_code, load_key, load_msg, done, serial_data}),
             int'(9'b0_1_0_00_0000));

    // Command table from IDLE/ERROR, ena gating and held-command error.
    for (int i = 0; i < 16; i++) begin
      ena = vecs[i].ena; host.cmd_valid = vecs[i].cv; host.cmd_op = vecs[i].op;
      tick();
      check($sformatf("vec%0d", i), status(), int'(vecs[i].exp));
    end
    reset_dut();

    // Full flow with an ena pause mid-message, then a second message
    // reusing the kept key and finishing on coincident done/end.
    load_run(1'b1, -1, -1);
    load_run(1'b0, MSG_BITS / 2, -1);
    run_crypto(1'b0);
    load_run(1'b0, -1, -1);
    run_crypto(1'b1);
    send_cmd(OP_START);
    check("start_after_done", status(), int'(5'b11101));
    send_cmd(OP_NOP);
    check("nop_recover", status(), int'(5'b01000));

    // START held three cycles while the key is loading.
    load_run(1'b1, -1, KEY_BITS - 4);
    reset_dut();

    // Asynchronous reset while draining, then flags must be gone.
    load_run(1'b1, -1, -1);
    load_run(1'b0, -1, -1);
    send_cmd(OP_START);
    key_ready = 1'b1; tick(); key_ready = 1'b0;
    encrypt_done = 1'b1; tick(); encrypt_done = 1'b0;
    #1 check("drain_before_reset", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset",
             int'({busy, host.cmd_ready, err, err_code, load_key, load_msg, done, serial_data}),
             int'(9'b0_1_0_00_0000));
    rst_n = 1'b1;
    tick();
    send_cmd(OP_NOP);
    send_cmd(OP_START);
    check("start_after_reset", status(), int'(5'b11101));
    reset_dut();

`ifdef XOR_CTRL_WATCHDOG_EN
    // Never finish encryption: the watchdog must fire 16 cycles in.
    load_run(1'b1, -1, -1);
    load_run(1'b0, -1, -1);
    send_cmd(OP_START);
    key_ready = 1'b1; tick(); key_ready = 1'b0;
    n = 0;
    while (n < 100 && err !== 1'b1) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, TIMEOUT_CYCLES);
    check("timeout_code", status(), int'(5'b11110));
`else
    n = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
